hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble sequencing, operand forwarding,
// memory-wait timeout supervision and saturating performance counters.
//
// state    | meaning
// RUN      | normal issue; stall, flush and load-use handled combinationally
// MEM_WAIT | data-memory access outstanding; wait_cnt counts stalled cycles
// ERROR    | memory wait exceeded TIMEOUT; pipeline frozen until reset
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             we_pc,
  output logic             we_fd,
  output logic             we_de,
  output logic             we_em,
  output logic             we_mw,
  output logic             empty_fd,
  output logic             empty_de,
  output logic             empty_mw,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_set;
  logic        mem_stall;
  logic        load_use;
  logic        stall_act;
  logic        flush_act;

  assign mem_stall = mem_req_m & ~mem_ready;
  assign load_use  = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set)
        mem_timeout <= 1'b1;
      if (stall_act && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_act && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end
      end
      MEM_WAIT: begin
        // completion and a withdrawn request both end the wait
        if (mem_ready || !mem_req_m) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 16'd0;
        end else if (wait_cnt == TIMEOUT_V) begin
          state_nxt   = ERROR;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_comb begin
    we_pc     = 1'b1;
    we_fd     = 1'b1;
    we_de     = 1'b1;
    we_em     = 1'b1;
    we_mw     = 1'b1;
    empty_fd  = 1'b0;
    empty_de  = 1'b0;
    empty_mw  = 1'b0;
    stall_act = 1'b0;
    flush_act = 1'b0;
    if (!rst || (state == ERROR)) begin
      we_pc = 1'b0;
      we_fd = 1'b0;
      we_de = 1'b0;
      we_em = 1'b0;
      we_mw = 1'b0;
    end else if (mem_stall) begin
      we_pc     = 1'b0;
      we_fd     = 1'b0;
      we_de     = 1'b0;
      we_em     = 1'b0;
      empty_mw  = 1'b1;
      stall_act = 1'b1;
    end else if (pc_src_e) begin
      // a flush squashes the dependent instruction, so load-use is moot
      empty_fd  = 1'b1;
      empty_de  = 1'b1;
      flush_act = 1'b1;
    end else if (load_use) begin
      we_pc     = 1'b0;
      we_fd     = 1'b0;
      empty_de  = 1'b1;
      stall_act = 1'b1;
    end
  end

  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (rst) begin
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_e))
        forward_a_e = 2'b10;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e))
        forward_a_e = 2'b01;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_e))
        forward_b_e = 2'b10;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e))
        forward_b_e = 2'b01;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised self-checking bench for hazard_ctrl: a default instance and a small
// instance (TIMEOUT=3, CNT_W=4) share stimulus and are checked against one model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       load_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready;

  logic        we_pc_a, we_fd_a, we_de_a, we_em_a, we_mw_a, empty_fd_a, empty_de_a, empty_mw_a;
  logic [1:0]  fwd_a_a, fwd_b_a;
  logic        to_a;
  logic [15:0] sc_a, fc_a;
  logic        we_pc_b, we_fd_b, we_de_b, we_em_b, we_mw_b, empty_fd_b, empty_de_b, empty_mw_b;
  logic [1:0]  fwd_a_b, fwd_b_b;
  logic        to_b;
  logic [3:0]  sc_b, fc_b;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .load_e(load_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .we_pc(we_pc_a), .we_fd(we_fd_a), .we_de(we_de_a), .we_em(we_em_a), .we_mw(we_mw_a),
    .empty_fd(empty_fd_a), .empty_de(empty_de_a), .empty_mw(empty_mw_a),
    .forward_a_e(fwd_a_a), .forward_b_e(fwd_b_a), .mem_timeout(to_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  hazard_ctrl #(.TIMEOUT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .load_e(load_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .we_pc(we_pc_b), .we_fd(we_fd_b), .we_de(we_de_b), .we_em(we_em_b), .we_mw(we_mw_b),
    .empty_fd(empty_fd_b), .empty_de(empty_de_b), .empty_mw(empty_mw_b),
    .forward_a_e(fwd_a_b), .forward_b_e(fwd_b_b), .mem_timeout(to_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  // {we_pc, we_fd, we_de, we_em, we_mw, empty_fd, empty_de, empty_mw}
  logic [7:0]  ctl_o [2];
  logic [3:0]  fwd_o [2];
  logic [15:0] sc_o  [2];
  logic [15:0] fc_o  [2];
  logic        to_o  [2];
  assign ctl_o[0] = {we_pc_a, we_fd_a, we_de_a, we_em_a, we_mw_a, empty_fd_a, empty_de_a, empty_mw_a};
  assign ctl_o[1] = {we_pc_b, we_fd_b, we_de_b, we_em_b, we_mw_b, empty_fd_b, empty_de_b, empty_mw_b};
  assign fwd_o[0] = {fwd_a_a, fwd_b_a};
  assign fwd_o[1] = {fwd_a_b, fwd_b_b};
  assign sc_o[0]  = sc_a;
  assign sc_o[1]  = {12'd0, sc_b};
  assign fc_o[0]  = fc_a;
  assign fc_o[1]  = {12'd0, fc_b};
  assign to_o[0]  = to_a;
  assign to_o[1]  = to_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: err is set once more than TIMEOUT consecutive cycles have stalled on memory.
  int unsigned run_len [2];
  int unsigned m_sc    [2];
  int unsigned m_fc    [2];
  bit          m_err   [2];

  function automatic int unsigned lim_to(int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic int unsigned lim_cnt(int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic bit is_stall();
    return mem_req_m && !mem_ready;
  endfunction

  function automatic bit is_lu();
    return load_e && (rd_e != 0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

  function automatic logic [7:0] exp_ctl(int i);
    if (rst !== 1'b1 || m_err[i]) return 8'b0000_0000;
    if (is_stall())               return 8'b0000_1001;
    if (pc_src_e)                 return 8'b1111_1110;
    if (is_lu())                  return 8'b0011_1010;
    return 8'b1111_1000;
  endfunction

  function automatic logic [1:0] exp_sel(logic [4:0] rs);
    if (rst !== 1'b1) return 2'b00;
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] exp_fwd();
    return {exp_sel(rs1_e), exp_sel(rs2_e)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run_len[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (rst !== 1'b1) return;
    for (int i = 0; i < 2; i++) begin
      if (!m_err[i]) begin
        if ((is_stall() || (!pc_src_e && is_lu())) && m_sc[i] < lim_cnt(i)) m_sc[i]++;
        if (!is_stall() && pc_src_e && m_fc[i] < lim_cnt(i)) m_fc[i]++;
        run_len[i] = is_stall() ? run_len[i] + 1 : 0;
        if (run_len[i] > lim_to(i)) m_err[i] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mem_req_m = 0; mem_ready = 0;
  endtask

  task automatic rand_inputs(int reg_max);
    rs1_d = 5'($urandom_range(0, reg_max)); rs2_d = 5'($urandom_range(0, reg_max));
    rs1_e = 5'($urandom_range(0, reg_max)); rs2_e = 5'($urandom_range(0, reg_max));
    rd_e  = 5'($urandom_range(0, reg_max)); rd_m  = 5'($urandom_range(0, reg_max));
    rd_w  = 5'($urandom_range(0, reg_max));
    load_e = 1'($urandom_range(0, 1)); reg_write_m = 1'($urandom_range(0, 1));
    reg_write_w = 1'($urandom_range(0, 1)); pc_src_e = ($urandom_range(0, 3) == 0);
    mem_req_m = ($urandom_range(0, 2) == 0); mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    rand_inputs(3);
    mem_req_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (ctl_o[i] !== 8'h00 || fwd_o[i] !== 4'h0) begin
          n_fail++;
          $display("FAIL reset_out[%0d] ctl=%b fwd=%b required ctl=00000000 fwd=0000", i, ctl_o[i], fwd_o[i]);
        end
        n_tests++;
        if (sc_o[i] !== 16'd0 || fc_o[i] !== 16'd0 || to_o[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_state[%0d] sc=%0d fc=%0d to=%b required 0 0 0", i, sc_o[i], fc_o[i], to_o[i]);
        end
      end
      tick();
    end
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    clear_inputs();
    load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5; rs1_d = 5'd9;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (ctl_o[i] !== 8'b0011_1010 || ctl_o[i] !== exp_ctl(i)) begin
        n_fail++;
        $display("FAIL load_use_ctl[%0d] got=%b required=%b", i, ctl_o[i], exp_ctl(i));
      end
    end
    tick();
    clear_inputs();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (sc_o[i] !== 16'd1 || sc_o[i] !== 16'(m_sc[i])) begin
        n_fail++;
        $display("FAIL load_use_cnt[%0d] got=%0d required=1", i, sc_o[i]);
      end
    end
    // rd_e = x0 never creates a load-use stall
    load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    n_tests++;
    if (ctl_o[0] !== 8'b1111_1000) begin
      n_fail++;
      $display("FAIL load_use_x0 got=%b required=11111000", ctl_o[0]);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_forward();
    logic [4:0] tab [3][3];
    logic [1:0] req [3];
    tab[0] = '{5'd3, 5'd3, 5'd3}; req[0] = 2'b10;
    tab[1] = '{5'd0, 5'd3, 5'd3}; req[1] = 2'b01;
    tab[2] = '{5'd3, 5'd3, 5'd0}; req[2] = 2'b00;
    clear_inputs();
    reg_write_m = 1'b1; reg_write_w = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_m = tab[k][0]; rd_w = tab[k][1]; rs1_e = tab[k][2];
      #1;
      n_tests++;
      if (fwd_a_a !== req[k] || fwd_a_b !== req[k]) begin
        n_fail++;
        $display("FAIL fwd_table[%0d] got=%b/%b required=%b", k, fwd_a_a, fwd_a_b, req[k]);
      end
    end
    for (int k = 0; k < 24; k++) begin
      rand_inputs(3);
      mem_req_m = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (fwd_o[i] !== exp_fwd()) begin
          n_fail++;
          $display("FAIL fwd_rand[%0d] got=%b required=%b", i, fwd_o[i], exp_fwd());
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_branch_lu();
    int unsigned sc0, fc0;
    pulse_reset();
    clear_inputs();
    sc0 = m_sc[0]; fc0 = m_fc[0];
    pc_src_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (ctl_o[i] !== 8'b1111_1110) begin
        n_fail++;
        $display("FAIL branch_lu_ctl[%0d] got=%b required=11111110", i, ctl_o[i]);
      end
    end
    tick();
    n_tests++;
    if (sc_o[0] !== 16'(sc0) || fc_o[0] !== 16'(fc0 + 1)) begin
      n_fail++;
      $display("FAIL branch_lu_cnt sc=%0d fc=%0d required sc=%0d fc=%0d", sc_o[0], fc_o[0], sc0, fc0 + 1);
    end
    clear_inputs();
  endtask

  task automatic test_mem_stall();
    pulse_reset();
    clear_inputs();
    mem_req_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (ctl_o[i] !== 8'b0000_1001) begin
          n_fail++;
          $display("FAIL mem_stall_ctl[%0d] cyc=%0d got=%b required=00001001", i, c, ctl_o[i]);
        end
      end
      tick();
    end
    mem_ready = 1'b1; pc_src_e = 1'b0;
    #1;
    n_tests++;
    if (sc_o[0] !== 16'd4 || ctl_o[0] !== 8'b1111_1000 || to_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_stall_done sc=%0d ctl=%b to=%b required 4 11111000 0", sc_o[0], ctl_o[0], to_o[0]);
    end
    n_tests++;
    if (to_o[1] !== 1'b1 || ctl_o[1] !== 8'h00 || sc_o[1] !== 16'd4) begin
      n_fail++;
      $display("FAIL timeout_enter to=%b ctl=%b sc=%0d required 1 00000000 4", to_o[1], ctl_o[1], sc_o[1]);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout_hold();
    for (int c = 0; c < 6; c++) begin
      rand_inputs(3);
      #1;
      n_tests++;
      if (ctl_o[1] !== 8'h00 || to_o[1] !== 1'b1 || sc_o[1] !== 16'd4 || fc_o[1] !== 16'(m_fc[1])) begin
        n_fail++;
        $display("FAIL error_hold ctl=%b to=%b sc=%0d fc=%0d required 00000000 1 4 %0d", ctl_o[1], to_o[1], sc_o[1], fc_o[1], m_fc[1]);
      end
      n_tests++;
      if (ctl_o[0] !== exp_ctl(0) || fwd_o[1] !== exp_fwd()) begin
        n_fail++;
        $display("FAIL error_side ctl_a=%b fwd_b=%b required %b %b", ctl_o[0], fwd_o[1], exp_ctl(0), exp_fwd());
      end
      tick();
    end
    // asynchronous reset applied mid-cycle clears the error at once
    clear_inputs();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (to_o[1] !== 1'b0 || sc_o[1] !== 16'd0 || ctl_o[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL error_reset to=%b sc=%0d ctl=%b required 0 0 00000000", to_o[1], sc_o[1], ctl_o[1]);
    end
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (ctl_o[1] !== 8'b1111_1000) begin
      n_fail++;
      $display("FAIL error_recover ctl=%b required=11111000", ctl_o[1]);
    end
    tick();
  endtask

  task automatic test_saturate();
    pulse_reset();
    clear_inputs();
    load_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
    for (int c = 0; c < 18; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (sc_o[i] !== 16'(m_sc[i])) begin
          n_fail++;
          $display("FAIL sat_step[%0d] cyc=%0d got=%0d required=%0d", i, c, sc_o[i], m_sc[i]);
        end
      end
    end
    n_tests++;
    if (sc_b !== 4'd15 || sc_a !== 16'd18) begin
      n_fail++;
      $display("FAIL sat_final sc_b=%0d sc_a=%0d required 15 18", sc_b, sc_a);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      rand_inputs((c % 2 == 0) ? 3 : 31);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (ctl_o[i] !== exp_ctl(i) || fwd_o[i] !== exp_fwd()) begin
          n_fail++;
          $display("FAIL rand_out[%0d] cyc=%0d ctl=%b fwd=%b required %b %b", i, c, ctl_o[i], fwd_o[i], exp_ctl(i), exp_fwd());
        end
        n_tests++;
        if (sc_o[i] !== 16'(m_sc[i]) || fc_o[i] !== 16'(m_fc[i]) || to_o[i] !== m_err[i]) begin
          n_fail++;
          $display("FAIL rand_state[%0d] cyc=%0d sc=%0d fc=%0d to=%b required %0d %0d %b", i, c, sc_o[i], fc_o[i], to_o[i], m_sc[i], m_fc[i], m_err[i]);
        end
      end
      tick();
    end
    rst = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #2;
    test_reset();
    test_load_use();
    test_forward();
    test_branch_lu();
    test_mem_stall();
    test_timeout_hold();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
